cpu_microsequencer: RTL

Parametrised microcode address sequencer for the Reclone CPU cores. It generalises the single-condition branch/increment sequencer built into the 6502 top level. It adds:
- selectable multi-condition branching
- a microcode subroutine call/return stack
- opcode dispatch
- built-in NMI/IRQ arbitration at instruction boundaries

It sits between the microcode ROM and the core datapath, and drives the ROM address every cycle.

---
 rtl/cpu_microsequencer_pkg.sv | 18 +
 rtl/cpu_microsequencer_stack.sv | 51 +++++
 rtl/cpu_microsequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_microsequencer_pkg.sv
// Shared microsequencer constants: next-address operation encodings and the
// default microcode vector addresses.
package cpu_microsequencer_pkg;

    typedef enum logic [2:0] {
        USEQ_OP_NEXT     = 3'd0,
        USEQ_OP_BRANCH   = 3'd1,
        USEQ_OP_CALL     = 3'd2,
        USEQ_OP_RETURN   = 3'd3,
        USEQ_OP_DISPATCH = 3'd4,
        USEQ_OP_POLL     = 3'd5
    } useq_op_e;

    localparam int unsigned USEQ_RESET_ADDR = 0;
    localparam int unsigned USEQ_NMI_ADDR   = 1;
    localparam int unsigned USEQ_IRQ_ADDR   = 2;

endpackage

// File: rtl/cpu_microsequencer_stack.sv
// Microcode return-address LIFO. Only the pointer is reset; entries are
// don't-care until written. The parent never pushes and pops together.
module cpu_microsequencer_stack #(
    parameter int ADDR_WIDTH  = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [ADDR_WIDTH-1:0] data_i,
    output logic [ADDR_WIDTH-1:0] top_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int PTR_W = $clog2(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [PTR_W:0]        sp_q;
    logic [PTR_W:0]        sp_d;
    logic [PTR_W-1:0]      top_idx;

    assign full_o  = (sp_q == (PTR_W+1)'(STACK_DEPTH));
    assign empty_o = (sp_q == '0);
    assign top_idx = sp_q[PTR_W-1:0] - PTR_W'(1);
    assign top_o   = mem_q[top_idx];

    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o) begin
            sp_d = sp_q + (PTR_W+1)'(1);
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(negedge clock) begin
        if (push_i && !full_o) begin
            mem_q[sp_q[PTR_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/cpu_microsequencer.sv
// Microcode address sequencer: branch/call/return/dispatch with NMI/IRQ
// arbitration at POLL boundaries. All state advances on the falling clock edge.
module cpu_microsequencer
    import cpu_microsequencer_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          STACK_DEPTH = 4,
    parameter int          COND_COUNT  = 8,
    parameter int unsigned RESET_ADDR  = USEQ_RESET_ADDR,
    parameter int unsigned NMI_ADDR    = USEQ_NMI_ADDR,
    parameter int unsigned IRQ_ADDR    = USEQ_IRQ_ADDR
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [2:0]                    uOp,
    input  logic [$clog2(COND_COUNT)-1:0] condSel,
    input  logic                          condPolarity,
    input  logic [COND_COUNT-1:0]         conditions,
    input  logic [ADDR_WIDTH-1:0]         branchAddr,
    input  logic [ADDR_WIDTH-1:0]         dispatchAddr,
    input  logic                          nNMI,
    input  logic                          nIRQ,
    input  logic                          irqMask,
    output logic [ADDR_WIDTH-1:0]         uCodeAddress,
    output logic                          intTaken,
    output logic                          intIsNmi,
    output logic                          nmiPending,
    output logic                          stackError
);
    localparam logic [ADDR_WIDTH-1:0] RESET_A = ADDR_WIDTH'(RESET_ADDR);
    localparam logic [ADDR_WIDTH-1:0] NMI_A   = ADDR_WIDTH'(NMI_ADDR);
    localparam logic [ADDR_WIDTH-1:0] IRQ_A   = ADDR_WIDTH'(IRQ_ADDR);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc, stack_top;
    logic                  err_q, err_d;
    logic                  taken_q, taken_d;
    logic                  isnmi_q, isnmi_d;
    logic                  nmi_pend_q, nmi_pend_d;
    logic                  nmi_samp_q;
    logic                  nmi_take;
    logic                  push, pop, full, empty;

    assign addr_inc = addr_q + ADDR_WIDTH'(1);

    cpu_microsequencer_stack #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clock  (clock),
        .reset  (reset),
        .push_i (push),
        .pop_i  (pop),
        .data_i (addr_inc),
        .top_o  (stack_top),
        .full_o (full),
        .empty_o(empty)
    );

    always_comb begin
        addr_d   = addr_q;
        err_d    = err_q;
        taken_d  = 1'b0;
        isnmi_d  = isnmi_q;
        nmi_take = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        if (enable) begin
            addr_d = addr_inc;
            case (uOp)
                USEQ_OP_BRANCH: begin
                    if (conditions[condSel] == condPolarity) addr_d = branchAddr;
                end
                USEQ_OP_CALL: begin
                    // A full stack drops the return address but the jump still happens.
                    push   = !full;
                    err_d  = err_q | full;
                    addr_d = branchAddr;
                end
                USEQ_OP_RETURN: begin
                    if (empty) begin
                        addr_d = RESET_A;
                        err_d  = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        addr_d = stack_top;
                    end
                end
                USEQ_OP_DISPATCH: addr_d = dispatchAddr;
                USEQ_OP_POLL: begin
                    if (nmi_pend_q) begin
                        addr_d   = NMI_A;
                        taken_d  = 1'b1;
                        isnmi_d  = 1'b1;
                        nmi_take = 1'b1;
                    end else if (!nIRQ && !irqMask) begin
                        addr_d  = IRQ_A;
                        taken_d = 1'b1;
                        isnmi_d = 1'b0;
                    end else begin
                        addr_d = dispatchAddr;
                    end
                end
                default: ;
            endcase
        end
        // A fresh falling edge wins over the clear from taking the NMI.
        nmi_pend_d = (nmi_samp_q & ~nNMI) | (nmi_pend_q & ~nmi_take);
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            addr_q     <= RESET_A;
            err_q      <= 1'b0;
            taken_q    <= 1'b0;
            isnmi_q    <= 1'b0;
            nmi_pend_q <= 1'b0;
            nmi_samp_q <= 1'b1;
        end else begin
            addr_q     <= addr_d;
            err_q      <= err_d;
            taken_q    <= taken_d;
            isnmi_q    <= isnmi_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_samp_q <= nNMI;
        end
    end

    assign uCodeAddress = addr_q;
    assign intTaken     = taken_q;
    assign intIsNmi     = isnmi_q;
    assign nmiPending   = nmi_pend_q;
    assign stackError   = err_q;

endmodule
